// File: rtl/rc4_job_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : rc4_job_sched_if
// Purpose  : Bundles the two requester channels, the response channel and the
//            RC4 core-side signals used by rc4_job_sched.
// Modports : slave  - scheduler view (consumes requests, drives core/response)
//            master - environment view (requesters, response consumer, core)
// Signals  : req_x/key_x/klen_x/gnt_x  requester A/B job channel
//            resp_valid/ready/id/err/data  tagged response channel
//            busy                          scheduler not idle
//            core_rst_n/start/key/key_length/ckey/done  RC4 core hookup
// Revision : 1.0 - initial release
// ============================================================================
interface rc4_job_sched_if #(
    parameter int NUMS_OF_BYTES = 4
);
    logic                       req_a;
    logic [31:0]                key_a;
    logic [7:0]                 klen_a;
    logic                       gnt_a;
    logic                       req_b;
    logic [31:0]                key_b;
    logic [7:0]                 klen_b;
    logic                       gnt_b;
    logic                       resp_valid;
    logic                       resp_ready;
    logic                       resp_id;
    logic                       resp_err;
    logic [NUMS_OF_BYTES*8-1:0] resp_data;
    logic                       busy;
    logic                       core_rst_n;
    logic                       core_start;
    logic [31:0]                core_key;
    logic [7:0]                 core_key_length;
    logic [NUMS_OF_BYTES*8-1:0] core_ckey;
    logic                       core_done;

    modport slave (
        input  req_a, key_a, klen_a, req_b, key_b, klen_b, resp_ready,
               core_ckey, core_done,
        output gnt_a, gnt_b, resp_valid, resp_id, resp_err, resp_data, busy,
               core_rst_n, core_start, core_key, core_key_length
    );

    modport master (
        output req_a, key_a, klen_a, req_b, key_b, klen_b, resp_ready,
               core_ckey, core_done,
        input  gnt_a, gnt_b, resp_valid, resp_id, resp_err, resp_data, busy,
               core_rst_n, core_start, core_key, core_key_length
    );
endinterface
`default_nettype wire

// File: rtl/rc4_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : rc4_job_sched
// Purpose  : Round-robin scheduler sharing one RC4 keystream core between two
//            requesters. Per job: grant + latch key, hold the core in reset,
//            launch it, wait for done, return ckey on a tagged valid/ready port.
// Ports    : clk   - system clock, rising edge
//            rst_n - synchronous active-low reset
//            bus   - rc4_job_sched_if.slave (requesters, response, core)
// Options  : RC4_TIMEOUT_EN - when defined, a watchdog aborts a launch that
//            sees no core done within TIMEOUT_CYCLES and answers with resp_err.
// Revision : 1.0 - initial release
// ============================================================================
module rc4_job_sched #(
    parameter int NUMS_OF_BYTES  = 4,
    parameter int CRST_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    rc4_job_sched_if.slave  bus
);
    localparam int             DW         = NUMS_OF_BYTES * 8;
    localparam int             CNT_MAX    = (CRST_CYCLES > TIMEOUT_CYCLES) ? CRST_CYCLES : TIMEOUT_CYCLES;
    localparam int             CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [7:0]     c_MAX_KLEN = 8'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CRST   = 2'd1,
        S_LAUNCH = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             state_q;
    logic               last_b_q;        // 1: B was granted last, A wins a tie
    logic               gnt_a_q;
    logic               gnt_b_q;
    logic               resp_valid_q;
    logic               resp_id_q;
    logic               resp_err_q;
    logic [DW-1:0]      resp_data_q;
    logic               core_rst_n_q;
    logic               core_start_q;
    logic [31:0]        core_key_q;
    logic [7:0]         core_klen_q;
    logic               done_q;          // core_done, one register stage
    logic               done_d1_q;       // previous sample, for edge detect
    logic               launch_first_q;  // first LAUNCH cycle, done ignored
    logic [CNT_W-1:0]   cnt_q;

    // Arbitration: a lone request wins; on a tie the pointer decides.
    logic               w_pick_a;
    logic               w_pick_b;
    logic [31:0]        w_key;
    logic [7:0]         w_klen;
    logic               w_klen_ok;
    logic               w_done_rise;

    assign w_pick_a    = bus.req_a & (~bus.req_b | last_b_q);
    assign w_pick_b    = bus.req_b & (~bus.req_a | ~last_b_q);
    assign w_key       = w_pick_b ? bus.key_b  : bus.key_a;
    assign w_klen      = w_pick_b ? bus.klen_b : bus.klen_a;
    assign w_klen_ok   = (w_klen != 8'd0) && (w_klen <= c_MAX_KLEN);
    // Only a rising edge counts, so a done level left over from before the
    // core reset can never complete a new job.
    assign w_done_rise = done_q & ~done_d1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            last_b_q       <= 1'b1;
            gnt_a_q        <= 1'b0;
            gnt_b_q        <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_data_q    <= '0;
            core_rst_n_q   <= 1'b0;
            core_start_q   <= 1'b0;
            core_key_q     <= '0;
            core_klen_q    <= '0;
            done_q         <= 1'b0;
            done_d1_q      <= 1'b0;
            launch_first_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            done_q    <= bus.core_done;
            done_d1_q <= done_q;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    core_rst_n_q <= 1'b1;
                    core_start_q <= 1'b0;
                    if (w_pick_a || w_pick_b) begin
                        gnt_a_q     <= w_pick_a;
                        gnt_b_q     <= w_pick_b;
                        core_key_q  <= w_key;
                        core_klen_q <= w_klen;
                        resp_id_q   <= w_pick_b;
                        last_b_q    <= w_pick_b;
                        cnt_q       <= '0;
                        if (w_klen_ok) begin
                            core_rst_n_q <= 1'b0;
                            state_q      <= S_CRST;
                        end else begin
                            // Rejected job: answer directly, core untouched.
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                            state_q      <= S_RESP;
                        end
                    end
                end

                S_CRST: begin
                    core_rst_n_q <= 1'b0;
                    core_start_q <= 1'b0;
                    if (cnt_q == CNT_W'(CRST_CYCLES - 1)) begin
                        core_rst_n_q   <= 1'b1;
                        core_start_q   <= 1'b1;
                        launch_first_q <= 1'b1;
                        cnt_q          <= '0;
                        state_q        <= S_LAUNCH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_LAUNCH: begin
                    launch_first_q <= 1'b0;
                    if (!launch_first_q && w_done_rise) begin
                        resp_data_q  <= bus.core_ckey;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        core_start_q <= 1'b0;
                        state_q      <= S_RESP;
                    end
`ifdef RC4_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        core_start_q <= 1'b0;
                        core_rst_n_q <= 1'b0;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`else
                    else begin
                        cnt_q <= cnt_q;
                    end
`endif
                end

                S_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        core_rst_n_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt_a           = gnt_a_q;
    assign bus.gnt_b           = gnt_b_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_id         = resp_id_q;
    assign bus.resp_err        = resp_err_q;
    assign bus.resp_data       = resp_data_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.core_rst_n      = core_rst_n_q;
    assign bus.core_start      = core_start_q;
    assign bus.core_key        = core_key_q;
    assign bus.core_key_length = core_klen_q;
endmodule
`default_nettype wire

// File: tb/tb_rc4_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc4_job_sched
// Purpose  : Directed self-checking bench for rc4_job_sched. A behavioural
//            RC4 core answers each launch after LAT cycles with the first four
//            keystream bytes computed by a reference RC4 function.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc4_job_sched;
    localparam int CRST = 2;
    localparam int TMO  = 16;
    localparam int LAT  = 3;

    logic clk;
    logic rst_n;
    logic tie_low;
    int   total;
    int   bad;
    int   start_cnt;
    int   overlap_cnt;
    int   lat_cnt;

    rc4_job_sched_if #(.NUMS_OF_BYTES(4)) bus ();

    rc4_job_sched #(
        .NUMS_OF_BYTES (4),
        .CRST_CYCLES   (CRST),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference RC4: key byte n = key[8n+:8], first four PRGA bytes.
    function automatic logic [31:0] rc4_ks(input logic [31:0] key, input logic [7:0] klen);
        logic [7:0]  s [256];
        logic [7:0]  t;
        logic [31:0] out;
        int          i;
        int          j;
        int          kl;
        kl = (klen == 8'd0) ? 1 : int'(klen);
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + int'(s[n]) + int'(key[8*(n%kl) +: 8])) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0; j = 0; out = '0;
        for (int n = 0; n < 4; n++) begin
            i = (i + 1) % 256;
            j = (j + int'(s[i])) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            out[8*n +: 8] = s[(int'(s[i]) + int'(s[j])) % 256];
        end
        return out;
    endfunction

    // Behavioural core: done rises LAT cycles after start is seen.
    always @(posedge clk) begin
        if (!bus.core_rst_n) begin
            bus.core_done <= 1'b0;
            bus.core_ckey <= '0;
            lat_cnt       <= 0;
        end else if (bus.core_start && !bus.core_done && !tie_low) begin
            if (lat_cnt == LAT - 1) begin
                bus.core_done <= 1'b1;
                bus.core_ckey <= rc4_ks(bus.core_key, bus.core_key_length);
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.core_start)           start_cnt   <= start_cnt + 1;
        if (bus.gnt_a && bus.gnt_b)   overlap_cnt <= overlap_cnt + 1;
    end

    task automatic wait_gnt(output int cyc);
        cyc = 0;
        while (!(bus.gnt_a || bus.gnt_b) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!bus.resp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic handshake;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.gnt_a, bus.gnt_b, bus.resp_valid, bus.resp_id, bus.resp_err, bus.busy,
             bus.core_rst_n, bus.core_start} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000000",
                {bus.gnt_a, bus.gnt_b, bus.resp_valid, bus.resp_id, bus.resp_err, bus.busy,
                 bus.core_rst_n, bus.core_start});
        end
        total++;
        if ({bus.resp_data, bus.core_key, bus.core_key_length} !== 72'h0) begin
            bad++; $display("FAIL reset_data got=%h want=0",
                {bus.resp_data, bus.core_key, bus.core_key_length});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.core_rst_n, bus.core_start, bus.busy} !== 3'b100) begin
            bad++; $display("FAIL idle_ctrl got=%b want=100", {bus.core_rst_n, bus.core_start, bus.busy});
        end
    endtask

    task automatic test_basic;
        int c;
        int lat;
        int drop;
        bus.req_a = 1'b1; bus.key_a = 32'h40302010; bus.klen_a = 8'd4;
        wait_gnt(c);
        total++;
        if (c !== 1) begin bad++; $display("FAIL basic_gnt_delay got=%0d want=1", c); end
        total++;
        if ({bus.gnt_a, bus.gnt_b, bus.busy, bus.core_rst_n} !== 4'b1010) begin
            bad++; $display("FAIL basic_gnt got=%b want=1010", {bus.gnt_a, bus.gnt_b, bus.busy, bus.core_rst_n});
        end
        total++;
        if ({bus.core_key, bus.core_key_length} !== {32'h40302010, 8'd4}) begin
            bad++; $display("FAIL basic_key got=%h want=4030201004", {bus.core_key, bus.core_key_length});
        end
        bus.req_a = 1'b0; bus.key_a = 32'hdeadbeef; bus.klen_a = 8'd0;
        @(negedge clk);
        total++;
        if ({bus.gnt_a, bus.core_rst_n, bus.core_start} !== 3'b000) begin
            bad++; $display("FAIL basic_crst2 got=%b want=000", {bus.gnt_a, bus.core_rst_n, bus.core_start});
        end
        @(negedge clk);
        total++;
        if ({bus.core_rst_n, bus.core_start} !== 2'b11) begin
            bad++; $display("FAIL basic_launch got=%b want=11", {bus.core_rst_n, bus.core_start});
        end
        lat = 2; drop = 0;
        while (!bus.resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            if (!bus.resp_valid && !bus.core_start) drop++;
        end
        total++;
        if (lat !== CRST + 2 + LAT) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, CRST + 2 + LAT); end
        total++;
        if (drop !== 0) begin bad++; $display("FAIL basic_start_held got=%0d want=0", drop); end
        total++;
        if ({bus.resp_id, bus.resp_err, bus.core_start} !== 3'b000) begin
            bad++; $display("FAIL basic_resp_tag got=%b want=000", {bus.resp_id, bus.resp_err, bus.core_start});
        end
        total++;
        if (bus.resp_data !== rc4_ks(32'h40302010, 8'd4)) begin
            bad++; $display("FAIL basic_data got=%h want=%h", bus.resp_data, rc4_ks(32'h40302010, 8'd4));
        end
        handshake();
        total++;
        if ({bus.resp_valid, bus.core_rst_n} !== 2'b00) begin
            bad++; $display("FAIL basic_after_hs got=%b want=00", {bus.resp_valid, bus.core_rst_n});
        end
        @(negedge clk);
        total++;
        if ({bus.core_rst_n, bus.busy} !== 2'b10) begin
            bad++; $display("FAIL basic_back_idle got=%b want=10", {bus.core_rst_n, bus.busy});
        end
    endtask

    task automatic test_round_robin;
        int c;
        int ov0;
        logic exp_b;
        logic [31:0] ek;
        rst_n = 1'b0;
        bus.req_a = 1'b1; bus.key_a = 32'h04030201; bus.klen_a = 8'd4;
        bus.req_b = 1'b1; bus.key_b = 32'h00aabbcc; bus.klen_b = 8'd3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ov0 = overlap_cnt;
        for (int k = 0; k < 4; k++) begin
            exp_b = k[0];
            wait_gnt(c);
            total++;
            if ({bus.gnt_a, bus.gnt_b} !== {~exp_b, exp_b}) begin
                bad++; $display("FAIL rr_order job=%0d got=%b want=%b", k, {bus.gnt_a, bus.gnt_b}, {~exp_b, exp_b});
            end
            @(negedge clk);
            total++;
            if ({bus.gnt_a, bus.gnt_b} !== 2'b00) begin
                bad++; $display("FAIL rr_pulse job=%0d got=%b want=00", k, {bus.gnt_a, bus.gnt_b});
            end
            wait_resp(c);
            ek = exp_b ? rc4_ks(32'h00aabbcc, 8'd3) : rc4_ks(32'h04030201, 8'd4);
            total++;
            if ({bus.resp_id, bus.resp_data} !== {exp_b, ek}) begin
                bad++; $display("FAIL rr_resp job=%0d got=%h want=%h", k, {bus.resp_id, bus.resp_data}, {exp_b, ek});
            end
            handshake();
            if (k == 3) begin bus.req_a = 1'b0; bus.req_b = 1'b0; end
        end
        @(negedge clk);
        total++;
        if (overlap_cnt !== ov0) begin bad++; $display("FAIL rr_overlap got=%0d want=%0d", overlap_cnt, ov0); end
    endtask

    task automatic test_bad_klen;
        int c;
        int s0;
        logic [7:0] lens [2];
        lens[0] = 8'd0; lens[1] = 8'd5;
        s0 = start_cnt;
        for (int k = 0; k < 2; k++) begin
            bus.req_b = 1'b1; bus.key_b = 32'h11223344; bus.klen_b = lens[k];
            wait_gnt(c);
            total++;
            if ({bus.gnt_a, bus.gnt_b, bus.resp_valid, bus.resp_err, bus.resp_id} !== 5'b01111) begin
                bad++; $display("FAIL badlen_flags klen=%0d got=%b want=01111", lens[k],
                    {bus.gnt_a, bus.gnt_b, bus.resp_valid, bus.resp_err, bus.resp_id});
            end
            total++;
            if (bus.resp_data !== 32'h0) begin bad++; $display("FAIL badlen_data got=%h want=0", bus.resp_data); end
            bus.req_b = 1'b0;
            handshake();
        end
        @(negedge clk);
        total++;
        if (start_cnt !== s0) begin bad++; $display("FAIL badlen_no_start got=%0d want=%0d", start_cnt, s0); end
    endtask

    task automatic test_stall;
        int c;
        int bad_cyc;
        logic [31:0] snap;
        bus.req_a = 1'b1; bus.key_a = 32'h00112233; bus.klen_a = 8'd3;
        wait_gnt(c);
        bus.req_a = 1'b0;
        wait_resp(c);
        snap = bus.resp_data;
        total++;
        if (snap !== rc4_ks(32'h00112233, 8'd3)) begin
            bad++; $display("FAIL stall_data got=%h want=%h", snap, rc4_ks(32'h00112233, 8'd3));
        end
        bus.req_b = 1'b1; bus.key_b = 32'h55667788; bus.klen_b = 8'd4;
        bad_cyc = 0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_data !== snap || bus.resp_id !== 1'b0 ||
                bus.resp_err !== 1'b0 || bus.gnt_a || bus.gnt_b) bad_cyc++;
        end
        total++;
        if (bad_cyc !== 0) begin bad++; $display("FAIL stall_hold got=%0d bad cycles want=0", bad_cyc); end
        handshake();
        total++;
        if ({bus.resp_valid, bus.gnt_b} !== 2'b00) begin
            bad++; $display("FAIL stall_no_early_gnt got=%b want=00", {bus.resp_valid, bus.gnt_b});
        end
        @(negedge clk);
        total++;
        if (bus.gnt_b !== 1'b1) begin bad++; $display("FAIL stall_gnt_after got=%b want=1", bus.gnt_b); end
        bus.req_b = 1'b0;
        wait_resp(c);
        total++;
        if ({bus.resp_id, bus.resp_data} !== {1'b1, rc4_ks(32'h55667788, 8'd4)}) begin
            bad++; $display("FAIL stall_b_resp got=%h want=%h", {bus.resp_id, bus.resp_data},
                {1'b1, rc4_ks(32'h55667788, 8'd4)});
        end
        handshake();
    endtask

    task automatic test_reset_mid;
        int c;
        int v;
        bus.req_a = 1'b1; bus.key_a = 32'h0a0b0c0d; bus.klen_a = 8'd2;
        wait_gnt(c);
        bus.req_a = 1'b0;
        c = 0;
        while (!bus.core_start && c < 20) begin @(negedge clk); c++; end
        total++;
        if (bus.core_start !== 1'b1) begin bad++; $display("FAIL midrst_launch got=%b want=1", bus.core_start); end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.gnt_a, bus.gnt_b, bus.resp_valid, bus.resp_err, bus.busy, bus.core_rst_n, bus.core_start} !== 7'b0) begin
            bad++; $display("FAIL midrst_ctrl got=%b want=0000000",
                {bus.gnt_a, bus.gnt_b, bus.resp_valid, bus.resp_err, bus.busy, bus.core_rst_n, bus.core_start});
        end
        total++;
        if ({bus.core_key, bus.core_key_length, bus.resp_data} !== 72'h0) begin
            bad++; $display("FAIL midrst_data got=%h want=0", {bus.core_key, bus.core_key_length, bus.resp_data});
        end
        rst_n = 1'b1;
        v = 0;
        repeat (10) begin @(negedge clk); if (bus.resp_valid) v++; end
        total++;
        if (v !== 0) begin bad++; $display("FAIL midrst_no_resp got=%0d want=0", v); end
        bus.req_a = 1'b1; bus.key_a = 32'h40302010; bus.klen_a = 8'd4;
        wait_gnt(c);
        bus.req_a = 1'b0;
        wait_resp(c);
        total++;
        if ({bus.resp_err, bus.resp_data} !== {1'b0, rc4_ks(32'h40302010, 8'd4)}) begin
            bad++; $display("FAIL midrst_fresh got=%h want=%h", {bus.resp_err, bus.resp_data},
                {1'b0, rc4_ks(32'h40302010, 8'd4)});
        end
        handshake();
    endtask

    task automatic test_timeout;
        int c;
        int lat;
        tie_low = 1'b1;
        bus.req_a = 1'b1; bus.key_a = 32'h01020304; bus.klen_a = 8'd4;
        wait_gnt(c);
        bus.req_a = 1'b0;
`ifdef RC4_TIMEOUT_EN
        wait_resp(lat);
        total++;
        if (lat !== CRST + TMO) begin bad++; $display("FAIL tmo_latency got=%0d want=%0d", lat, CRST + TMO); end
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_id, bus.core_rst_n, bus.core_start} !== 5'b11000) begin
            bad++; $display("FAIL tmo_flags got=%b want=11000",
                {bus.resp_valid, bus.resp_err, bus.resp_id, bus.core_rst_n, bus.core_start});
        end
        total++;
        if (bus.resp_data !== 32'h0) begin bad++; $display("FAIL tmo_data got=%h want=0", bus.resp_data); end
        handshake();
        tie_low = 1'b0;
        lat = 0;
`else
        lat = 0;
        repeat (60) begin @(negedge clk); if (bus.resp_valid) lat++; end
        total++;
        if ({lat != 0, bus.core_start} !== 2'b01) begin
            bad++; $display("FAIL nodone_wait got=%b want=01", {lat != 0, bus.core_start});
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tie_low = 1'b0;
`endif
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL tmo_recover got=%b want=0", bus.busy); end
    endtask

    initial begin
        total = 0; bad = 0; tie_low = 1'b0; rst_n = 1'b0;
        bus.req_a = 1'b0; bus.key_a = '0; bus.klen_a = '0;
        bus.req_b = 1'b0; bus.key_b = '0; bus.klen_b = '0;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_round_robin();
        test_bad_klen();
        test_stall();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
